axi4_ram_slave: RTL and testbench



---
 rtl/axi4_ram_slave.sv | 209 ++++++++++++++++++++
 tb/tb_axi4_ram_slave.sv | 534 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_ram_slave.sv
`default_nettype none
// ============================================================================
// Module  : axi4_ram_slave
// Brief   : Single-outstanding AXI4 slave backed by a byte-strobed word RAM.
// Revision: 1.0 - initial release
// ============================================================================
module axi4_ram_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);
   localparam int         BYTES       = DATA_WIDTH / 8;
   localparam int         OFF_W       = $clog2(BYTES);
   localparam int         IDX_W       = $clog2(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_t;

   state_t                  state_q;
   logic                    prio_q;      // 0: read wins a collision, 1: write wins
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [1:0]              burst_q;
   logic [7:0]              len_q;
   logic [7:0]              cnt_q;
   logic                    rd_more_q;
   logic                    werr_q;
   logic [1:0]              bresp_q;
   logic                    a_valid_q;
   logic                    a_last_q;
   logic                    a_err_q;
   logic                    rvalid_q;
   logic                    rlast_q;
   logic [1:0]              rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   ram_rd_q;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic                    w_aw_grant;
   logic                    w_ar_grant;
   logic                    w_w_fire;
   logic                    w_b_load;
   logic                    w_rd_issue;
   logic [ADDR_WIDTH-1:0]   w_rd_addr;
   logic                    w_unused_awlen;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (a >> (IDX_W + OFF_W)) == '0;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[IDX_W+OFF_W-1:OFF_W];
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
      return (burst == BURST_FIXED) ? a : a + ADDR_WIDTH'(BYTES);
   endfunction

   assign w_aw_grant = (state_q == ST_IDLE) && s_axi_awvalid && (!s_axi_arvalid || prio_q);
   assign w_ar_grant = (state_q == ST_IDLE) && s_axi_arvalid && (!s_axi_awvalid || !prio_q);
   assign w_w_fire   = (state_q == ST_WRITE) && s_axi_wvalid;

   // Two-stage read pipe: RAM output register (stage A) feeding the R register.
   // A new RAM read is only issued when stage A is empty or draining this cycle.
   assign w_b_load   = a_valid_q && (!rvalid_q || s_axi_rready);
   assign w_rd_issue = w_ar_grant ||
                       ((state_q == ST_READ) && rd_more_q && (!a_valid_q || w_b_load));
   assign w_rd_addr  = (state_q == ST_IDLE) ? s_axi_araddr : addr_q;

   assign w_unused_awlen = ^s_axi_awlen;

   always_ff @(posedge clk) begin
      if (w_w_fire && in_range(addr_q)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (s_axi_wstrb[b]) begin
               mem_q[word_idx(addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
         end
      end
      if (w_rd_issue) begin
         ram_rd_q <= mem_q[word_idx(w_rd_addr)];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         prio_q    <= 1'b0;
         addr_q    <= '0;
         burst_q   <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         rd_more_q <= 1'b0;
         werr_q    <= 1'b0;
         bresp_q   <= RESP_OKAY;
         a_valid_q <= 1'b0;
         a_last_q  <= 1'b0;
         a_err_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_aw_grant) begin
                  state_q <= ST_WRITE;
                  addr_q  <= s_axi_awaddr;
                  burst_q <= s_axi_awburst;
                  werr_q  <= 1'b0;
                  prio_q  <= ~prio_q;
               end else if (w_ar_grant) begin
                  state_q   <= ST_READ;
                  addr_q    <= next_addr(s_axi_araddr, s_axi_arburst);
                  burst_q   <= s_axi_arburst;
                  len_q     <= s_axi_arlen;
                  cnt_q     <= 8'd1;
                  rd_more_q <= (s_axi_arlen != 8'd0);
                  prio_q    <= ~prio_q;
               end
            end
            ST_WRITE: begin
               if (s_axi_wvalid) begin
                  addr_q <= next_addr(addr_q, burst_q);
                  werr_q <= werr_q || !in_range(addr_q);
                  if (s_axi_wlast) begin
                     state_q <= ST_WRESP;
                     bresp_q <= (werr_q || !in_range(addr_q)) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            ST_WRESP: begin
               if (s_axi_bready) begin
                  state_q <= ST_IDLE;
                  bresp_q <= RESP_OKAY;
               end
            end
            ST_READ: begin
               if (w_rd_issue) begin
                  addr_q    <= next_addr(addr_q, burst_q);
                  cnt_q     <= cnt_q + 8'd1;
                  rd_more_q <= (cnt_q != len_q);
               end
               if (rvalid_q && s_axi_rready && rlast_q) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (w_rd_issue) begin
            a_valid_q <= 1'b1;
            a_last_q  <= w_ar_grant ? (s_axi_arlen == 8'd0) : (cnt_q == len_q);
            a_err_q   <= !in_range(w_rd_addr);
         end else if (w_b_load) begin
            a_valid_q <= 1'b0;
         end

         if (w_b_load) begin
            rvalid_q <= 1'b1;
            rdata_q  <= a_err_q ? '0 : ram_rd_q;
            rresp_q  <= a_err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_q  <= a_last_q;
         end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign s_axi_awready = w_aw_grant;
   assign s_axi_arready = w_ar_grant;
   assign s_axi_wready  = (state_q == ST_WRITE);
   assign s_axi_bvalid  = (state_q == ST_WRESP);
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_ram_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4_ram_slave
// Brief   : Scoreboard bench for axi4_ram_slave (32-bit data, 1024 words).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi4_ram_slave;
   typedef struct packed {
      logic        last;
      logic [1:0]  resp;
      logic [31:0] data;
   } beat_t;

   logic        clk;
   logic        reset_n;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int cyc      = 0;
   int stall_viol;
   int extra_beats;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] ref_mem [int];
   beat_t       exp_q [$];
   beat_t       got_q [$];

   axi4_ram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (1024)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_axi_awaddr  (awaddr),
      .s_axi_awlen   (awlen),
      .s_axi_awburst (awburst),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wlast   (wlast),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_arburst (arburst),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rlast   (rlast),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt + 1);
      $fatal(1, "watchdog expired");
   end

   // Reference memory: a beat hits RAM when its byte address is below 4 KiB.
   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [1:0] burst,
                                              input int n);
      logic [31:0] a   = addr;
      logic        err = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (a < 32'h1000) begin
            logic [31:0] w;
            w = ref_mem.exists(int'(a[11:2])) ? ref_mem[int'(a[11:2])] : 32'h0;
            for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
            ref_mem[int'(a[11:2])] = w;
         end else begin
            err = 1'b1;
         end
         if (burst != 2'b00) a = a + 32'd4;
      end
      return err ? 2'b10 : 2'b00;
   endfunction

   function automatic void model_read(input logic [31:0] addr, input logic [1:0] burst,
                                      input int len);
      logic [31:0] a = addr;
      for (int i = 0; i <= len; i++) begin
         beat_t e;
         e.last = (i == len);
         if (a < 32'h1000) begin
            e.resp = 2'b00;
            e.data = ref_mem[int'(a[11:2])];
         end else begin
            e.resp = 2'b10;
            e.data = 32'h0;
         end
         exp_q.push_back(e);
         if (burst != 2'b00) a = a + 32'd4;
      end
   endfunction

   task automatic clear_inputs();
      awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [1:0] burst, input int n,
                            output logic [1:0] resp, output int aw2w, output int w2b);
      int aw_cyc;
      int wl_cyc;
      @(posedge clk); #1;
      awaddr = addr; awburst = burst; awlen = 8'(n - 1); awvalid = 1'b1;
      @(negedge clk);
      while (!awready) @(negedge clk);
      aw_cyc = cyc;
      @(posedge clk); #1;
      awvalid = 1'b0;
      aw2w = -1;
      wl_cyc = 0;
      for (int i = 0; i < n; i++) begin
         wdata = wd[i]; wstrb = ws[i]; wlast = (i == n - 1); wvalid = 1'b1;
         @(negedge clk);
         while (!wready) @(negedge clk);
         if (i == 0) aw2w = cyc - aw_cyc;
         if (i == n - 1) wl_cyc = cyc;
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      @(negedge clk);
      while (!bvalid) @(negedge clk);
      w2b  = cyc - wl_cyc;
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   // Observes beats into got_q; rpat[c%4] sets rready on cycle c after the AR handshake.
   task automatic axi_read(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                           input logic [3:0] rpat, output int lat, output int ar_wait);
      int    ar_cyc;
      int    c     = 0;
      bit    done  = 0;
      bit    first = 1;
      bit    held  = 0;
      beat_t hb;
      stall_viol  = 0;
      extra_beats = 0;
      lat         = -1;
      @(posedge clk); #1;
      araddr = addr; arburst = burst; arlen = len; arvalid = 1'b1;
      ar_wait = 0;
      @(negedge clk);
      while (!arready) begin
         ar_wait++;
         @(negedge clk);
      end
      ar_cyc = cyc;
      @(posedge clk); #1;
      arvalid = 1'b0;
      while (!done && c < 2000) begin
         rready = rpat[c % 4];
         c++;
         @(negedge clk);
         if (rvalid) begin
            if (first) begin
               lat   = cyc - ar_cyc;
               first = 0;
            end
            if (held && ({rlast, rresp, rdata} !== hb)) stall_viol++;
            if (rready) begin
               got_q.push_back({rlast, rresp, rdata});
               held = 0;
               if (rlast) done = 1;
            end else begin
               held = 1;
               hb   = {rlast, rresp, rdata};
            end
         end else if (held) begin
            stall_viol++;
         end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      @(negedge clk);
      if (rvalid) extra_beats++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vec_cnt++;
      if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
         miss_cnt++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {awready, arready, wready, bvalid, rvalid, rlast});
      end
      vec_cnt++;
      if ({rdata, rresp, bresp} !== 36'h0) begin
         miss_cnt++;
         $display("FAIL reset_data: got %h expected 0", {rdata, rresp, bresp});
      end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if ({wready, bvalid, rvalid} !== 3'b0) begin
         miss_cnt++;
         $display("FAIL reset_release: got %b expected 000", {wready, bvalid, rvalid});
      end
   endtask

   task automatic test_single();
      logic [1:0] resp;
      logic [1:0] eresp;
      int         aw2w, w2b, lat, arw;
      beat_t      e, g;
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      eresp = model_write(32'h10, 2'b01, 1);
      axi_write(32'h10, 2'b01, 1, resp, aw2w, w2b);
      vec_cnt++;
      if (resp !== eresp) begin
         miss_cnt++; $display("FAIL single_bresp: got %b expected %b", resp, eresp);
      end
      vec_cnt++;
      if (aw2w !== 1 || w2b !== 1) begin
         miss_cnt++; $display("FAIL single_wtiming: got aw2w=%0d w2b=%0d expected 1/1", aw2w, w2b);
      end
      model_read(32'h10, 2'b01, 0);
      axi_read(32'h10, 2'b01, 8'd0, 4'b1111, lat, arw);
      vec_cnt++;
      if (lat !== 2) begin
         miss_cnt++; $display("FAIL single_rlat: got %0d expected 2", lat);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (got_q.size() == 0) begin
            miss_cnt++; $display("FAIL single_beat: got none expected %h", e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin miss_cnt++; $display("FAIL single_beat: got %h expected %h", g, e); end
         end
      end
      got_q.delete();
   endtask

   task automatic test_incr_backpressure();
      logic [1:0] resp;
      logic [1:0] eresp;
      int         aw2w, w2b, lat, arw;
      beat_t      e, g;
      for (int i = 0; i < 8; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
      eresp = model_write(32'h100, 2'b01, 8);
      axi_write(32'h100, 2'b01, 8, resp, aw2w, w2b);
      vec_cnt++;
      if (resp !== eresp) begin
         miss_cnt++; $display("FAIL incr_bresp: got %b expected %b", resp, eresp);
      end
      model_read(32'h100, 2'b01, 7);
      axi_read(32'h100, 2'b01, 8'd7, 4'b1001, lat, arw);
      vec_cnt++;
      if (lat !== 2) begin
         miss_cnt++; $display("FAIL incr_rlat: got %0d expected 2", lat);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (got_q.size() == 0) begin
            miss_cnt++; $display("FAIL incr_beat: got none expected %h", e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin miss_cnt++; $display("FAIL incr_beat: got %h expected %h", g, e); end
         end
      end
      vec_cnt++;
      if (got_q.size() != 0 || extra_beats != 0) begin
         miss_cnt++;
         $display("FAIL incr_extra: got %0d extra beats expected 0", got_q.size() + extra_beats);
      end
      vec_cnt++;
      if (stall_viol != 0) begin
         miss_cnt++; $display("FAIL incr_stall: got %0d unstable stalls expected 0", stall_viol);
      end
      got_q.delete();
   endtask

   task automatic test_strobe_fixed();
      logic [1:0] resp;
      logic [1:0] eresp;
      int         aw2w, w2b, lat, arw;
      beat_t      e, g;
      wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
      void'(model_write(32'h20, 2'b01, 1));
      axi_write(32'h20, 2'b01, 1, resp, aw2w, w2b);
      wd[0] = 32'h00000011; ws[0] = 4'h1;
      wd[1] = 32'h00002200; ws[1] = 4'h2;
      wd[2] = 32'h00330000; ws[2] = 4'h4;
      wd[3] = 32'h44000000; ws[3] = 4'h8;
      eresp = model_write(32'h20, 2'b00, 4);
      axi_write(32'h20, 2'b00, 4, resp, aw2w, w2b);
      vec_cnt++;
      if (resp !== eresp) begin
         miss_cnt++; $display("FAIL fixed_bresp: got %b expected %b", resp, eresp);
      end
      model_read(32'h20, 2'b01, 0);
      axi_read(32'h20, 2'b01, 8'd0, 4'b1111, lat, arw);
      model_read(32'h20, 2'b00, 2);
      axi_read(32'h20, 2'b00, 8'd2, 4'b0101, lat, arw);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (got_q.size() == 0) begin
            miss_cnt++; $display("FAIL strobe_beat: got none expected %h", e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin miss_cnt++; $display("FAIL strobe_beat: got %h expected %h", g, e); end
         end
      end
      got_q.delete();
   endtask

   task automatic test_out_of_range();
      logic [1:0] resp;
      logic [1:0] eresp;
      int         aw2w, w2b, lat, arw;
      beat_t      e, g;
      wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
      void'(model_write(32'h0, 2'b01, 1));
      axi_write(32'h0, 2'b01, 1, resp, aw2w, w2b);
      wd[0] = 32'hA5A5A5A5; ws[0] = 4'hF;
      wd[1] = 32'h5A5A5A5A; ws[1] = 4'hF;
      eresp = model_write(32'hFFC, 2'b01, 2);
      axi_write(32'hFFC, 2'b01, 2, resp, aw2w, w2b);
      vec_cnt++;
      if (resp !== eresp) begin
         miss_cnt++; $display("FAIL oor_bresp: got %b expected %b", resp, eresp);
      end
      model_read(32'hFFC, 2'b01, 1);
      axi_read(32'hFFC, 2'b01, 8'd1, 4'b1111, lat, arw);
      model_read(32'h1000, 2'b01, 0);
      axi_read(32'h1000, 2'b01, 8'd0, 4'b1111, lat, arw);
      model_read(32'h0, 2'b01, 0);
      axi_read(32'h0, 2'b01, 8'd0, 4'b1111, lat, arw);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (got_q.size() == 0) begin
            miss_cnt++; $display("FAIL oor_beat: got none expected %h", e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin miss_cnt++; $display("FAIL oor_beat: got %h expected %h", g, e); end
         end
      end
      got_q.delete();
   endtask

   task automatic test_arbitration();
      logic [1:0]  gr;
      logic [31:0] rd0;
      bit          got0;
      beat_t       e, g;
      logic [1:0]  eresp;
      do_reset();
      @(posedge clk); #1;
      awaddr = 32'h40; awburst = 2'b01; awlen = 8'd0; awvalid = 1'b1;
      araddr = 32'h10; arburst = 2'b01; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if ({awready, arready} !== 2'b01) begin
         miss_cnt++; $display("FAIL arb_first: got aw/ar %b expected 01", {awready, arready});
      end
      @(posedge clk); #1;
      araddr = 32'h40;
      gr = 2'b00; got0 = 0; rd0 = '0;
      for (int i = 0; i < 20 && gr == 2'b00; i++) begin
         @(negedge clk);
         if (rvalid && !got0) begin rd0 = rdata; got0 = 1; end
         gr = {awready, arready};
         if (gr == 2'b00) begin @(posedge clk); #1; end
      end
      vec_cnt++;
      if (!got0 || rd0 !== ref_mem[4]) begin
         miss_cnt++; $display("FAIL arb_read0: got %h (seen=%0d) expected %h", rd0, got0, ref_mem[4]);
      end
      vec_cnt++;
      if (gr !== 2'b10) begin
         miss_cnt++; $display("FAIL arb_second: got aw/ar %b expected 10", gr);
      end
      wd[0] = 32'h12345678; ws[0] = 4'hF;
      eresp = model_write(32'h40, 2'b01, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wdata = wd[0]; wstrb = ws[0]; wlast = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      while (!wready) @(negedge clk);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      @(negedge clk);
      while (!bvalid) @(negedge clk);
      vec_cnt++;
      if (bresp !== eresp) begin
         miss_cnt++; $display("FAIL arb_bresp: got %b expected %b", bresp, eresp);
      end
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      while (!arready) @(negedge clk);
      @(posedge clk); #1;
      arvalid = 1'b0;
      model_read(32'h40, 2'b01, 0);
      @(negedge clk);
      while (!rvalid) @(negedge clk);
      got_q.push_back({rlast, rresp, rdata});
      @(posedge clk); #1;
      rready = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         g = got_q.pop_front();
         if (g !== e) begin miss_cnt++; $display("FAIL arb_raw: got %h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp;
      logic [1:0] eresp;
      int         aw2w, w2b, lat, arw;
      int         beats = 0;
      beat_t      e, g;
      for (int i = 0; i < 6; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
      eresp = model_write(32'h200, 2'b01, 6);
      axi_write(32'h200, 2'b01, 6, resp, aw2w, w2b);
      vec_cnt++;
      if (resp !== eresp) begin
         miss_cnt++; $display("FAIL rstmid_bresp: got %b expected %b", resp, eresp);
      end
      @(posedge clk); #1;
      araddr = 32'h200; arburst = 2'b01; arlen = 8'd5; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      while (!arready) @(negedge clk);
      @(posedge clk); #1;
      arvalid = 1'b0;
      for (int i = 0; i < 20 && beats < 3; i++) begin
         @(negedge clk);
         if (rvalid) beats++;
      end
      reset_n = 1'b0;
      #1;
      vec_cnt++;
      if (beats !== 3) begin
         miss_cnt++; $display("FAIL rstmid_beats: got %0d beats before reset expected 3", beats);
      end
      vec_cnt++;
      if ({rvalid, rlast, rresp, rdata, bvalid, wready} !== 38'h0) begin
         miss_cnt++;
         $display("FAIL rstmid_outputs: got %h expected 0", {rvalid, rlast, rresp, rdata, bvalid, wready});
      end
      rready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      model_read(32'h200, 2'b01, 5);
      axi_read(32'h200, 2'b01, 8'd5, 4'b1111, lat, arw);
      vec_cnt++;
      if (arw !== 0 || lat !== 2) begin
         miss_cnt++; $display("FAIL rstmid_idle: got arwait=%0d lat=%0d expected 0/2", arw, lat);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (got_q.size() == 0) begin
            miss_cnt++; $display("FAIL rstmid_beat: got none expected %h", e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin miss_cnt++; $display("FAIL rstmid_beat: got %h expected %h", g, e); end
         end
      end
      got_q.delete();
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      test_reset();
      test_single();
      test_incr_backpressure();
      test_strobe_fixed();
      test_out_of_range();
      test_arbitration();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
`default_nettype wire
